// File: rtl/regfile_16x24.sv
// Sixteen-entry register file for the 24-bit datapath: two combinational read
// ports with write-through bypass, one synchronous write port, R0 tied to zero.
module regfile_16x24 #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [7:0]        WriteCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              write_en;

    // Writes aimed at R0 are dropped entirely, including from the write count.
    assign write_en = RegWrite && (WriteAddr != '0);

    // NOTE: the storage array is reset explicitly because the datapath relies on
    // every register reading 0 after reset; non-blocking assignments keep all
    // state updates on this edge consistent with one another.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            WriteCount <= '0;
        end else if (write_en) begin
            regs[WriteAddr] <= WriteData;
            if (WriteCount != 8'hFF) begin
                WriteCount <= WriteCount + 8'd1;
            end
        end
    end

    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        ReadData1 = '0;
        if (Reset && (ReadAddr1 != '0)) begin
            if (write_en && (WriteAddr == ReadAddr1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs[ReadAddr1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (Reset && (ReadAddr2 != '0)) begin
            if (write_en && (WriteAddr == ReadAddr2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs[ReadAddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_16x24.sv
// Scoreboard bench for regfile_16x24: a driver pushes expected read/count values
// from an array model; a negedge monitor pops and compares them.
module tb_regfile_16x24;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [3:0]  WriteAddr = '0;
    logic [23:0] WriteData = '0;
    logic [3:0]  ReadAddr1 = '0;
    logic [3:0]  ReadAddr2 = '0;
    logic [23:0] ReadData1;
    logic [23:0] ReadData2;
    logic [7:0]  WriteCount;

    regfile_16x24 dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .RegWrite  (RegWrite),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .ReadAddr1 (ReadAddr1),
        .ReadAddr2 (ReadAddr2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .WriteCount(WriteCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [23:0] rd1;
        logic [23:0] rd2;
        logic [7:0]  cnt;
    } expect_t;

    expect_t     sb_q[$];
    int          checks = 0;
    int          failures = 0;

    // Reference model: plain array plus integer write counter.
    logic [23:0] model_mem [16];
    int          model_cnt = 0;

    task automatic check(input string name, input logic [23:0] actual, input logic [23:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic logic [23:0] model_read(input logic [3:0] addr);
        if (!Reset || addr == 4'd0) return 24'd0;
        if (RegWrite && WriteAddr != 4'd0 && WriteAddr == addr) return WriteData;
        return model_mem[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = 24'd0;
        model_cnt = 0;
    endtask

    // Applies the write the DUT is sampling on this edge.
    task automatic model_commit();
        if (!Reset) begin
            model_clear();
        end else if (RegWrite && WriteAddr != 4'd0) begin
            model_mem[WriteAddr] = WriteData;
            if (model_cnt < 255) model_cnt++;
        end
    endtask

    task automatic push_expect(input string name);
        expect_t e;
        e.name = name;
        e.rd1  = model_read(ReadAddr1);
        e.rd2  = model_read(ReadAddr2);
        e.cnt  = 8'(model_cnt);
        sb_q.push_back(e);
    endtask

    task automatic cycle(input string name, input logic we, input logic [3:0] wa,
                         input logic [23:0] wd, input logic [3:0] r1, input logic [3:0] r2);
        @(posedge Clock);
        model_commit();
        #1;
        RegWrite  = we;
        WriteAddr = wa;
        WriteData = wd;
        ReadAddr1 = r1;
        ReadAddr2 = r2;
        push_expect(name);
    endtask

    always @(negedge Clock) begin
        while (sb_q.size() > 0) begin
            expect_t e;
            e = sb_q.pop_front();
            check({e.name, ".rd1"}, ReadData1, e.rd1);
            check({e.name, ".rd2"}, ReadData2, e.rd2);
            check({e.name, ".cnt"}, {16'd0, WriteCount}, {16'd0, e.cnt});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    logic [23:0] last_data;

    initial begin
        model_clear();
        Reset     = 1'b0;
        RegWrite  = 1'b1;
        WriteAddr = 4'd5;
        WriteData = 24'hABCDEF;
        ReadAddr1 = 4'd5;
        ReadAddr2 = 4'd5;

        // Writes presented during reset must be ignored.
        for (int i = 0; i < 3; i++) cycle("in_reset", 1'b1, 4'd5, 24'hABCDEF, 4'd5, 4'd5);
        @(posedge Clock);
        model_commit();
        #1;
        Reset    = 1'b1;
        RegWrite = 1'b0;
        push_expect("reset_release");
        cycle("after_reset", 1'b0, 4'd0, 24'd0, 4'd5, 4'd0);

        // Basic write/read.
        cycle("wr_r3", 1'b1, 4'd3, 24'h123456, 4'd0, 4'd0);
        cycle("wr_r15", 1'b1, 4'd15, 24'hFFFFFF, 4'd0, 4'd0);
        cycle("rd_3_15", 1'b0, 4'd0, 24'd0, 4'd3, 4'd15);
        cycle("rd_3_15_hold", 1'b0, 4'd0, 24'd0, 4'd3, 4'd15);

        // R0 protection, including a bypass attempt at index 0.
        cycle("wr_r0", 1'b1, 4'd0, 24'h00BEEF, 4'd0, 4'd0);
        cycle("rd_r0", 1'b0, 4'd0, 24'd0, 4'd0, 4'd0);

        // Bypass on both ports to the same register.
        cycle("load_r7", 1'b1, 4'd7, 24'h000111, 4'd7, 4'd7);
        cycle("bypass_r7", 1'b1, 4'd7, 24'h000222, 4'd7, 4'd7);
        cycle("after_bypass", 1'b0, 4'd0, 24'd0, 4'd7, 4'd3);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            cycle("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 24'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Load R1..R15 with their index, then drop reset between edges.
        for (int i = 1; i < 16; i++) cycle("load_idx", 1'b1, 4'(i), 24'(i), 4'(i), 4'(16 - i));
        cycle("idx_read", 1'b0, 4'd0, 24'd0, 4'd4, 4'd15);
        @(posedge Clock);
        model_commit();
        #1;
        RegWrite  = 1'b1;
        WriteAddr = 4'd9;
        WriteData = 24'h0A0A0A;
        ReadAddr1 = 4'd9;
        ReadAddr2 = 4'd15;
        #1;
        Reset = 1'b0;
        model_clear();
        push_expect("async_reset");
        for (int i = 1; i < 16; i++) cycle("reset_held", 1'b1, 4'(i), 24'hFFFFFF, 4'(i), 4'(16 - i));
        @(posedge Clock);
        model_commit();
        #1;
        Reset    = 1'b1;
        RegWrite = 1'b0;
        push_expect("reset_release2");
        for (int i = 1; i < 16; i++) cycle("cleared", 1'b0, 4'd0, 24'd0, 4'(i), 4'(16 - i));

        // Saturation: 300 writes to R9.
        last_data = 24'd0;
        for (int i = 0; i < 300; i++) begin
            last_data = 24'($urandom);
            cycle("sat_wr", 1'b1, 4'd9, last_data, 4'd9, 4'd1);
        end
        cycle("sat_rd", 1'b0, 4'd0, 24'd0, 4'd9, 4'd9);
        cycle("sat_wr_more", 1'b1, 4'd2, 24'h5A5A5A, 4'd2, 4'd9);
        cycle("sat_final", 1'b0, 4'd0, 24'd0, 4'd2, 4'd9);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge Clock);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked", sb_q.size());
        end
        if (model_cnt != 255) begin
            failures++;
            $display("FAIL model_sat: model count %0d, expected 255", model_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_16x24.md
# regfile_16x24

Register file for the 24-bit CPU datapath: sixteen 24-bit general-purpose registers with two asynchronous read ports and one synchronous write port. It sits directly downstream of the 4-bit destination-register select mux, which chooses between the instruction's rt and rd fields. That mux output drives `WriteAddr` here. The read ports feed the ALU operand path. Register 0 is hardwired to zero.

## Interface
- `DATA_W`, 24, register width in bits.
- `ADDR_W`, 4, register address width; depth = 2^ADDR_W = 16.
- `Clock`  in  1  single system clock; all state changes occur on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset; clears every register to 0 while low.
- `RegWrite`  in  1  write enable, sampled on the rising edge of `Clock`.
- `WriteAddr`  in  ADDR_W  destination register index, from the 4-bit destination select mux.
- `WriteData`  in  DATA_W  data to write.
- `ReadAddr1`  in  ADDR_W  source register index for port 1 (rs field).
- `ReadAddr2`  in  ADDR_W  source register index for port 2 (rt field).
- `ReadData1`  out  DATA_W  contents of register `ReadAddr1`.
- `ReadData2`  out  DATA_W  contents of register `ReadAddr2`.
- `WriteCount`  out  8  saturating count of committed writes since reset; debug and verification aid.

## Operation
- Storage: 16 x 24-bit registers, R0..R15.
- R0:
  - never written; writes to index 0 are dropped;
  - `WriteCount` does not increment for them;
  - reads of index 0 always return 0.
- Write: on a rising edge with `Reset` high, `RegWrite`=1 and `WriteAddr`!=0:
  - R[`WriteAddr`] <= `WriteData`;
  - `WriteCount` increments, saturating at 255.
- Read: combinational.
  - `ReadDataN` = R[`ReadAddrN`], or 0 when `ReadAddrN`=0.
- Write-through bypass: when `RegWrite`=1, `WriteAddr`!=0 and `WriteAddr`==`ReadAddrN`, `ReadDataN` = `WriteData` in the same cycle.
  - This lets a writeback and an operand fetch in the same cycle see the new value.
  - The bypass is gated by `Reset` high; while in reset, reads return 0.
- Both read ports may address the same register; both return the same value, with bypass applied independently per port.
- Only `DATA_W` bits are stored; no sign extension or truncation takes place inside the block.

## Timing
- Reset is asynchronous:
  - `Reset` falling clears all registers and `WriteCount` immediately, without waiting for a clock edge;
  - the outputs show 0 within the same delta cycle.
- While `Reset` is low, the block holds all state at 0 and ignores all writes.
- First write is accepted on the first rising edge at which `Reset` is high.
- Reset asserted mid-operation, while a write is pending: the write is lost and the register reads 0 after reset.
- Write latency: the value is visible on an unbypassed read one cycle after the edge. Bypassed reads see it in the same cycle, with combinational latency.
- Read latency: 0 cycles, purely combinational from `ReadAddrN`.
- Reset values of outputs: `ReadData1`=0, `ReadData2`=0, `WriteCount`=0.
- `WriteCount` saturation: at 255, further writes still commit data, but the count stays at 255.

## Test plan
- Reset: hold `Reset`=0 with `RegWrite`=1, `WriteAddr`=5, `WriteData`=24'hABCDEF for 3 edges, then release. Required: R5 reads 0 and `WriteCount`=0.
- Basic write/read: write 24'h123456 to R3 and 24'hFFFFFF to R15; read ports at 3 and 15. Required:
  - `ReadData1`=24'h123456 and `ReadData2`=24'hFFFFFF one cycle later;
  - `WriteCount`=2.
- R0 protection: write 24'h00BEEF to R0, then read both ports at 0. Required: both ports return 0 and `WriteCount` is unchanged.
- Bypass: R7 holds 24'h000111; in the same cycle drive `RegWrite`=1, `WriteAddr`=7, `WriteData`=24'h000222, `ReadAddr1`=`ReadAddr2`=7. Required: both ports show 24'h000222 before the edge, and R7=24'h000222 after it.
- Async reset mid-run: load R1..R15 with their own index values, then pull `Reset` low between clock edges. Required: all reads drop to 0 immediately, without waiting for a clock edge, and `WriteCount`=0.
- Saturation: perform 300 writes to R9. Required: `WriteCount`=255, and R9 holds the last written value.
